button_event_decoder: RTL
=========================

Name: button_event_decoder

Overview:
- Consumes the debounced button level and turns it into single-cycle event pulses: press, release, click (short press), long_press and auto-repeat.
- Sits between a button debouncer and the game control FSMs, so game logic never has to time button levels itself.
- All outputs are registered; one decoder instance per button.

Parameters:
- CNT_LEN, 26, width of the hold-time counter; must satisfy 2^CNT_LEN > max(LONG_VALUE, REPEAT_VALUE).
- LONG_VALUE, 50_000_000, hold cycles from the press pulse to long_press (0.5 s at 100 MHz); must be >= 2.
- REPEAT_VALUE, 10_000_000, cycles between repeat pulses after long_press; must be >= 2.
- REPEAT_EN, 1, 1 = generate repeat pulses while held past long_press; 0 = none.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- btn_db  input  1  debounced button level, 1 = pressed, synchronous to clk.
- press  output  1  one-cycle pulse on a button press.
- release  output  1  one-cycle pulse on a button release.
- click  output  1  one-cycle pulse on a release that comes before long_press.
- long_press  output  1  one-cycle pulse when the hold reaches LONG_VALUE.
- repeat  output  1  one-cycle auto-repeat pulse.
- held  output  1  level, 1 while the FSM is in PRESSED or HELD.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=IDLE, counter=0.
  - press, release, click, long_press, repeat and held all 0.
  - Previous-level register btn_q=1, so a button held through reset produces no press.
- btn_q <= btn_db every non-reset cycle. rise = btn_db & ~btn_q.
- Cycle numbering: P = the first cycle press is high. Every event output is registered and appears one cycle after the btn_db sample that causes it.
- States: IDLE, PRESSED, HELD (2-bit encoding). Any illegal state returns to IDLE with all pulses 0.
- IDLE:
  - On rise: press=1 next cycle, counter=0, go to PRESSED.
  - A falling level in IDLE is ignored.
- PRESSED:
  - If btn_db=0: release=1 and click=1 next cycle, go to IDLE, counter=0.
  - Else if the hold has reached LONG_VALUE: long_press=1 in cycle P+LONG_VALUE, counter=0, go to HELD.
  - Else counter+1.
- HELD:
  - If btn_db=0: release=1 next cycle (no click), go to IDLE, counter=0.
  - Else if REPEAT_EN and the count has reached REPEAT_VALUE: repeat=1 in cycles P+LONG_VALUE+k*REPEAT_VALUE (k>=1), counter=0.
  - Else counter+1. With REPEAT_EN=0 the counter holds at 0 and no repeat is produced.
- Simultaneous events: a release always wins.
  - A fall sampled on the long_press threshold cycle gives release+click and no long_press.
  - A fall sampled on a repeat cycle gives release and no repeat.
- Pulse exclusivity: at most one of press, long_press and repeat is high in any cycle. click is only ever high together with release.
- held is registered: 1 from cycle P through the cycle before release is high, 0 otherwise.
- Counter arithmetic: unsigned CNT_LEN bits. It is cleared on every state change and never wraps, given the parameter constraints.
- Reset mid-operation: at the next edge everything returns to the reset values and any in-flight pulse is dropped. No press is issued until btn_db has been seen at 0 and then at 1.
- Back-to-back: a re-press sampled the cycle after a release is accepted. The press pulse may directly follow the release cycle.

Test Plan (CNT_LEN=4, LONG_VALUE=8, REPEAT_VALUE=4 unless stated):
1. Hold reset=0 for 3 cycles with btn_db toggling -> all outputs stay 0; held=0.
2. btn_db high for 5 samples, then low -> press in cycle P; release=click=1 in P+5; long_press=repeat=0 throughout; held=1 in P..P+4.
3. REPEAT_EN=1, btn_db high for 20 samples -> long_press in P+8; repeat in P+12 and P+16; release in P+20 with click=0 and no repeat in P+20.
4. btn_db high for exactly 8 samples -> release=click=1 in P+8; long_press never asserted.
5. btn_db high, reset=0 in P+3..P+4, btn_db stays high -> outputs 0 from P+4; no press after reset; btn_db low then high -> normal press.
6. REPEAT_EN=0, btn_db high for 20 samples -> long_press in P+8 only; zero repeat pulses; release in P+20.

Source files
------------

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into registered one-cycle event pulses
// (press, release, click, long press, auto-repeat) plus a held level.
module button_event_decoder #(
  parameter int unsigned CNT_LEN      = 26,
  parameter int unsigned LONG_VALUE   = 50_000_000,
  parameter int unsigned REPEAT_VALUE = 10_000_000,
  parameter bit          REPEAT_EN    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_db,
  output logic press,
  output logic release_p,
  output logic click,
  output logic long_press,
  output logic repeat_p,
  output logic held
);

  // Terminal counts: the counter starts at 0 on the state entry cycle.
  localparam logic [CNT_LEN-1:0] LONG_LAST   = CNT_LEN'(LONG_VALUE - 1);
  localparam logic [CNT_LEN-1:0] REPEAT_LAST = CNT_LEN'(REPEAT_VALUE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_LEN-1:0] cnt_q, cnt_d;
  logic               btn_q, btn_d;
  logic               press_q, press_d;
  logic               release_q, release_d;
  logic               click_q, click_d;
  logic               long_q, long_d;
  logic               repeat_q, repeat_d;
  logic               held_q, held_d;
  logic               rise;

  // Previous level resets high so a button held through reset gives no press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      btn_q     <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_q     <= btn_d;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign rise = btn_db & ~btn_q;

  // Next state, hold counter and event pulses; a release always wins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    btn_d     = btn_db;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) begin
          press_d = 1'b1;
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        if (!btn_db) begin
          release_d = 1'b1;
          click_d   = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          cnt_d   = '0;
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + CNT_LEN'(1);
        end
      end
      HELD: begin
        if (!btn_db) begin
          release_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (!REPEAT_EN) begin
          cnt_d = '0;
        end else if (cnt_q == REPEAT_LAST) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_LEN'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    held_d = (state_d != IDLE);
  end

  assign press      = press_q;
  assign release_p  = release_q;
  assign click      = click_q;
  assign long_press = long_q;
  assign repeat_p   = repeat_q;
  assign held       = held_q;

endmodule
